// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state type and helpers for the M-ary FSK modulator
package fsk_pkg;
  typedef enum logic {IDLE, TX} state_t;
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction
  function automatic int unsigned tone_lsb(input int unsigned sym, input int unsigned w);
    return sym * w;
  endfunction
endpackage

// File: rtl/fsk_tone_gen.sv
// fsk_tone_gen: phase-continuous square wave with a programmable half-period
module fsk_tone_gen #(
  parameter int HALF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] half_q,
  input  logic              run,
  input  logic              force_low,
  output logic              dout
);
  logic [HALF_W-1:0] tone_cnt;
  logic wrap;
  assign wrap = tone_cnt >= half_q - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tone_cnt <= '0;
      dout     <= 1'b0;
    end else if (force_low) begin
      tone_cnt <= '0;
      dout     <= 1'b0;
    end else if (run) begin
      tone_cnt <= wrap ? '0 : tone_cnt + 1'b1;
      dout     <= dout ^ wrap;
    end
endmodule

// File: rtl/fsk_mod_mary.sv
// fsk_mod_mary: M-ary FSK modulator with valid/ready symbol input and phase-continuous tone switching
module fsk_mod_mary
  import fsk_pkg::*;
#(
  parameter int BITS_PER_SYM = 1,
  parameter int HALF_W       = 8,
  parameter int SYM_LEN_W    = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [(2**BITS_PER_SYM)*HALF_W-1:0]  tone_half_i,
  input  logic [SYM_LEN_W-1:0]                 sym_len_i,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [BITS_PER_SYM-1:0]              s_sym,
  output logic                                 dout,
  output logic                                 busy,
  output logic                                 eot
);
  state_t state;
  logic [SYM_LEN_W-1:0] sym_cnt, len_q, len_new;
  logic [HALF_W-1:0] half_q, half_new;
  logic last, accept, force_low;
  assign last      = (state == TX) && (sym_cnt == len_q - 1'b1);
  assign s_ready   = (state == IDLE) || last;
  assign accept    = s_valid && s_ready;
  assign force_low = (state == IDLE) || (last && !accept);
  assign half_new  = HALF_W'(clamp1(32'(tone_half_i >> tone_lsb(int'(s_sym), HALF_W))));
  assign len_new   = SYM_LEN_W'(clamp1(32'(sym_len_i)));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      sym_cnt <= '0;
      len_q   <= '0;
      half_q  <= '0;
      busy    <= 1'b0;
      eot     <= 1'b0;
    end else begin
      eot <= 1'b0;
      if (accept) begin
        state   <= TX;
        busy    <= 1'b1;
        half_q  <= half_new;
        len_q   <= len_new;
        sym_cnt <= '0;
      end else if (last) begin
        state   <= IDLE;
        busy    <= 1'b0;
        eot     <= 1'b1;
        sym_cnt <= '0;
      end else if (state == TX) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  fsk_tone_gen #(.HALF_W(HALF_W)) u_tone (
    .clk       (clk),
    .rst       (rst),
    .half_q    (half_q),
    .run       (state == TX),
    .force_low (force_low),
    .dout      (dout)
  );
endmodule

// File: tb/tb_fsk_mod_mary.sv
// tb_fsk_mod_mary: directed self-checking bench for the M-ary FSK modulator
module tb_fsk_mod_mary;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] tone1;
  logic [9:0] len1;
  logic v1, r1, sym1, d1, b1, e1;
  logic [31:0] tone2;
  logic [9:0] len2;
  logic v2, r2, d2, b2, e2;
  logic [1:0] sym2;
  int checks = 0;
  int errors = 0;
  fsk_mod_mary #(.BITS_PER_SYM(1), .HALF_W(8), .SYM_LEN_W(10)) u_dut1 (
    .clk(clk), .rst(rst), .tone_half_i(tone1), .sym_len_i(len1), .s_valid(v1),
    .s_ready(r1), .s_sym(sym1), .dout(d1), .busy(b1), .eot(e1)
  );
  fsk_mod_mary #(.BITS_PER_SYM(2), .HALF_W(8), .SYM_LEN_W(10)) u_dut2 (
    .clk(clk), .rst(rst), .tone_half_i(tone2), .sym_len_i(len2), .s_valid(v2),
    .s_ready(r2), .s_sym(sym2), .dout(d2), .busy(b2), .eot(e2)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    int tog[$];
    int exp_tog[16] = '{7, 14, 21, 23, 25, 27, 29, 31, 33, 35, 37, 39, 44, 49, 54, 59};
    logic prev;
    tone1 = '0; len1 = '0; v1 = 1'b0; sym1 = 1'b0;
    tone2 = '0; len2 = '0; v2 = 1'b0; sym2 = '0;
    repeat (2) step();
    chk("rst_dout1", int'(d1), 0);
    chk("rst_busy1", int'(b1), 0);
    chk("rst_eot1", int'(e1), 0);
    chk("rst_ready1", int'(r1), 1);
    chk("rst_dout2", int'(d2), 0);
    chk("rst_busy2", int'(b2), 0);
    chk("rst_ready2", int'(r2), 1);
    rst = 1'b1;
    step();
    tone1 = {8'd4, 8'd8}; len1 = 10'd64; sym1 = 1'b1; v1 = 1'b1;
    chk("legacy_ready_idle", int'(r1), 1);
    step();
    sym1 = 1'b0;
    for (int n = 0; n <= 129; n++) begin
      if (n > 0) step();
      if (n == 64) v1 = 1'b0;
      chk($sformatf("legacy_dout n=%0d", n), int'(d1), n <= 64 ? (n / 4) % 2 : (n < 128 ? ((n - 64) / 8) % 2 : 0));
      chk($sformatf("legacy_ready n=%0d", n), int'(r1), int'(n == 63 || n == 127 || n >= 128));
      chk($sformatf("legacy_busy n=%0d", n), int'(b1), int'(n < 128));
      chk($sformatf("legacy_eot n=%0d", n), int'(e1), int'(n == 128));
    end
    tone1 = {8'd3, 8'd8}; len1 = 10'd15; sym1 = 1'b0; v1 = 1'b1;
    step();
    sym1 = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) step();
      if (n == 15) v1 = 1'b0;
      chk($sformatf("phase_dout n=%0d", n), int'(d1), n < 8 ? 0 : (n < 16 ? 1 : ((n - 16) / 3) % 2));
      chk($sformatf("phase_busy n=%0d", n), int'(b1), int'(n < 30));
      chk($sformatf("phase_eot n=%0d", n), int'(e1), int'(n == 30));
    end
    step();
    tone1 = {8'd2, 8'd2}; len1 = 10'd10; sym1 = 1'b1; v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) step();
      chk($sformatf("eos_dout n=%0d", n), int'(d1), n < 10 ? (n / 2) % 2 : 0);
      chk($sformatf("eos_busy n=%0d", n), int'(b1), int'(n < 10));
      chk($sformatf("eos_eot n=%0d", n), int'(e1), int'(n == 10));
      chk($sformatf("eos_ready n=%0d", n), int'(r1), int'(n >= 9));
    end
    tone1 = '0; len1 = '0; sym1 = 1'b0; v1 = 1'b1;
    step();
    for (int n = 0; n <= 7; n++) begin
      if (n > 0) step();
      if (n == 5) v1 = 1'b0;
      chk($sformatf("zero_dout n=%0d", n), int'(d1), n < 6 ? n % 2 : 0);
      chk($sformatf("zero_ready n=%0d", n), int'(r1), 1);
      chk($sformatf("zero_busy n=%0d", n), int'(b1), int'(n < 6));
      chk($sformatf("zero_eot n=%0d", n), int'(e1), int'(n == 6));
    end
    tone2 = {8'd7, 8'd5, 8'd3, 8'd2}; len2 = 10'd20; sym2 = 2'd3; v2 = 1'b1;
    step();
    sym2 = 2'd0;
    prev = d2;
    for (int n = 0; n <= 61; n++) begin
      if (n > 0) step();
      if (n == 20) sym2 = 2'd2;
      if (n == 40) v2 = 1'b0;
      if (n > 0 && d2 != prev) tog.push_back(n);
      prev = d2;
      if (n == 60) chk("mary_eot", int'(e2), 1);
    end
    chk("mary_toggle_count", tog.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mary_toggle_edge i=%0d", i), i < tog.size() ? tog[i] : -1, exp_tog[i]);
    sym2 = 2'd1; v2 = 1'b1;
    step();
    v2 = 1'b0;
    repeat (4) step();
    chk("arst_pre_dout", int'(d2), 1);
    chk("arst_pre_busy", int'(b2), 1);
    chk("arst_pre_ready", int'(r2), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", int'(d2), 0);
    chk("arst_busy", int'(b2), 0);
    chk("arst_ready", int'(r2), 1);
    chk("arst_eot", int'(e2), 0);
    step();
    rst = 1'b1;
    step();
    sym2 = 2'd0; v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int n = 0; n <= 5; n++) begin
      if (n > 0) step();
      chk($sformatf("arst_restart_dout n=%0d", n), int'(d2), (n / 2) % 2);
      chk($sformatf("arst_restart_busy n=%0d", n), int'(b2), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
